// File: rtl/gray_updown_counter.sv
// -----------------------------------------------------------------------------
// gray_updown_counter
//
// Prescaled up/down counter that publishes its value both in binary and in
// Gray code. A free-running prescaler produces a one-cycle `tick` every DIV
// clocks. On a tick with `en` high, the counter steps up or down. It either
// wraps or saturates at its limits, depending on WRAP. A synchronous `load`
// takes a Gray-coded value at any time, independent of tick and en.
//
// Parameters
//   WIDTH  counter width in bits (2..16)
//   DIV    clk cycles per step tick (>= 1; DIV = 1 ticks every cycle)
//   WRAP   1 = wrap-around, 0 = saturate at all-ones / zero
//
// Ports
//   clk        in   rising-edge clock for all state
//   rst        in   synchronous, active-high reset
//   en         in   step enable, only looked at on tick cycles
//   up         in   step direction: 1 = increment, 0 = decrement
//   load       in   synchronous load of load_gray (beats a step)
//   load_gray  in   [WIDTH] Gray-coded load value
//   tick       out  combinational, high while the prescaler sits at DIV-1
//   bin        out  [WIDTH] registered binary count
//   gray       out  [WIDTH] registered Gray code of bin (same cycle as bin)
//   tc         out  registered one-cycle terminal-count pulse
// -----------------------------------------------------------------------------
module gray_updown_counter #(
  parameter int WIDTH = 4,
  parameter int DIV   = 100_000_000,
  parameter int WRAP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic             tick,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             tc
);

  // Smallest width that holds DIV-1. Keep at least one bit so that DIV = 1
  // still gives a legal vector. In that case the register simply stays at 0.
  localparam int              PRESC_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);
  localparam bit              SATURATE   = (WRAP == 0);

  logic [PRESC_W-1:0] presc;

  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] bin_next;
  logic [WIDTH-1:0] gray_next;
  logic             tc_next;
  logic             step;
  logic             at_boundary;
  logic             blocked;

  // ---------------------------------------------------------------------------
  // Prescaler: free-running 0..DIV-1. Only rst touches it. A load neither
  // restarts nor pauses it, so the step cadence never drifts.
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments, so every flop samples
  // pre-edge values regardless of the order in which the blocks are evaluated.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
    end else if (presc == PRESC_LAST) begin
      presc <= '0;
    end else begin
      presc <= presc + PRESC_W'(1);
    end
  end

  assign tick = (presc == PRESC_LAST);

  // ---------------------------------------------------------------------------
  // Gray -> binary. Bit i of the binary value is the XOR of all Gray bits at
  // or above i. This is the closed form of b[i] = b[i+1] ^ g[i]. It avoids a
  // combinational chain that reads back its own output.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      load_bin[i] = ^(load_gray >> i);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Priority is load > step > hold. rst is applied in the
  // register block.
  //   at_boundary : pre-step value is the limit for the current direction
  //   blocked     : saturating mode refuses to move past that limit
  // tc flags any step that starts at the boundary. This includes a blocked
  // step, so tc also fires while the counter sits at its limit in
  // saturating mode.
  // ---------------------------------------------------------------------------
  assign step        = tick & en;
  assign at_boundary = up ? (&bin) : (bin == '0);
  assign blocked     = SATURATE & at_boundary;

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and turn it into a latch.
  always_comb begin
    bin_next = bin;
    tc_next  = 1'b0;
    if (load) begin
      bin_next = load_bin;
    end else if (step) begin
      tc_next = at_boundary;
      if (!blocked) begin
        bin_next = up ? (bin + WIDTH'(1)) : (bin - WIDTH'(1));
      end
    end
  end

  // gray is registered from the next binary value. It therefore never lags
  // bin. A load passes load_gray through unchanged.
  assign gray_next = load ? load_gray : (bin_next ^ (bin_next >> 1));

  // ---------------------------------------------------------------------------
  // Output registers.
  // ---------------------------------------------------------------------------
  // NOTE: reset is synchronous and explicit for every flop. Declaration
  // initial values are never relied on to define state.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin  <= '0;
      gray <= '0;
      tc   <= 1'b0;
    end else begin
      bin  <= bin_next;
      gray <= gray_next;
      tc   <= tc_next;
    end
  end

endmodule

// File: tb/tb_gray_updown_counter.sv
// -----------------------------------------------------------------------------
// tb_gray_updown_counter
//
// Directed bench for three configurations that share one clock and one reset:
//   dut_a : WIDTH=4, DIV=4, WRAP=1  (wrap sequence, down from reset, load,
//                                    reset colliding with tick/load)
//   dut_b : WIDTH=4, DIV=4, WRAP=0  (saturation at both limits)
//   dut_c : WIDTH=8, DIV=1, WRAP=1  (tick every cycle, full 256-step sweep)
// Inputs change and outputs are checked on the falling edge.
// -----------------------------------------------------------------------------
module tb_gray_updown_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       en_a, up_a, load_a, tick_a, tc_a;
  logic [3:0] lg_a, bin_a, gray_a;

  logic       en_b, up_b, load_b, tick_b, tc_b;
  logic [3:0] lg_b, bin_b, gray_b;

  logic       en_c, up_c, load_c, tick_c, tc_c;
  logic [7:0] lg_c, bin_c, gray_c;

  int errors = 0;
  int checks = 0;

  gray_updown_counter #(.WIDTH(4), .DIV(4), .WRAP(1)) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .up(up_a), .load(load_a),
    .load_gray(lg_a), .tick(tick_a), .bin(bin_a), .gray(gray_a), .tc(tc_a)
  );

  gray_updown_counter #(.WIDTH(4), .DIV(4), .WRAP(0)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .up(up_b), .load(load_b),
    .load_gray(lg_b), .tick(tick_b), .bin(bin_b), .gray(gray_b), .tc(tc_b)
  );

  gray_updown_counter #(.WIDTH(8), .DIV(1), .WRAP(1)) dut_c (
    .clk(clk), .rst(rst), .en(en_c), .up(up_c), .load(load_c),
    .load_gray(lg_c), .tick(tick_c), .bin(bin_c), .gray(gray_c), .tc(tc_c)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hand-written 4-bit Gray sequence for counts 0..15, followed by the wrap.
  logic [3:0] gseq [0:16];

  logic [7:0] prev_gray_c;

  initial begin
    gseq[0]  = 4'b0000; gseq[1]  = 4'b0001; gseq[2]  = 4'b0011;
    gseq[3]  = 4'b0010; gseq[4]  = 4'b0110; gseq[5]  = 4'b0111;
    gseq[6]  = 4'b0101; gseq[7]  = 4'b0100; gseq[8]  = 4'b1100;
    gseq[9]  = 4'b1101; gseq[10] = 4'b1111; gseq[11] = 4'b1110;
    gseq[12] = 4'b1010; gseq[13] = 4'b1011; gseq[14] = 4'b1001;
    gseq[15] = 4'b1000; gseq[16] = 4'b0000;

    rst  = 1'b1;
    en_a = 1'b0; up_a = 1'b1; load_a = 1'b0; lg_a = 4'h0;
    en_b = 1'b0; up_b = 1'b1; load_b = 1'b0; lg_b = 4'h0;
    en_c = 1'b0; up_c = 1'b1; load_c = 1'b0; lg_c = 8'h00;

    // ---- reset state ------------------------------------------------------
    cyc(3);
    check("rst_bin_a",  32'(bin_a),  32'h0);
    check("rst_gray_a", 32'(gray_a), 32'h0);
    check("rst_tc_a",   32'(tc_a),   32'h0);
    check("rst_tick_a", 32'(tick_a), 32'h0);
    check("rst_bin_b",  32'(bin_b),  32'h0);
    check("rst_tick_c", 32'(tick_c), 32'h1);

    // ---- A: count up through a full wrap ------------------------------------
    rst = 1'b0; en_a = 1'b1; up_a = 1'b1;
    cyc(1); check("a_tick_n1", 32'(tick_a), 32'h0);
    cyc(1); check("a_tick_n2", 32'(tick_a), 32'h0);
    cyc(1); check("a_tick_n3", 32'(tick_a), 32'h1);
    for (int k = 1; k <= 16; k++) begin
      cyc(1);
      check($sformatf("a_up_bin_%0d", k),  32'(bin_a),  32'(k % 16));
      check($sformatf("a_up_gray_%0d", k), 32'(gray_a), 32'(gseq[k]));
      check($sformatf("a_up_tc_%0d", k),   32'(tc_a),   (k == 16) ? 32'h1 : 32'h0);
      cyc(1);
      check($sformatf("a_up_tc_drop_%0d", k), 32'(tc_a), 32'h0);
      cyc(2);
    end

    // ---- A: count down from reset -------------------------------------------
    rst = 1'b1; up_a = 1'b0;
    cyc(2);
    check("a_rst2_bin", 32'(bin_a), 32'h0);
    rst = 1'b0;
    cyc(4);
    check("a_dn1_bin",  32'(bin_a),  32'hF);
    check("a_dn1_gray", 32'(gray_a), 32'h8);
    check("a_dn1_tc",   32'(tc_a),   32'h1);
    cyc(1);
    check("a_dn1_tc_drop", 32'(tc_a), 32'h0);
    cyc(2);
    check("a_dn_tick", 32'(tick_a), 32'h1);
    cyc(1);
    check("a_dn2_bin",  32'(bin_a),  32'hE);
    check("a_dn2_gray", 32'(gray_a), 32'h9);
    check("a_dn2_tc",   32'(tc_a),   32'h0);

    // ---- A: load inside a tick cycle wins over the step ---------------------
    cyc(3);
    check("a_ld_tick", 32'(tick_a), 32'h1);
    load_a = 1'b1; lg_a = 4'b0110;
    cyc(1);
    load_a = 1'b0;
    check("a_ld_bin",  32'(bin_a),  32'h4);
    check("a_ld_gray", 32'(gray_a), 32'h6);
    check("a_ld_tc",   32'(tc_a),   32'h0);
    cyc(2);
    check("a_ld_phase_lo", 32'(tick_a), 32'h0);
    cyc(1);
    check("a_ld_phase_hi", 32'(tick_a), 32'h1);
    cyc(1);
    check("a_ld_step_bin",  32'(bin_a),  32'h3);
    check("a_ld_step_gray", 32'(gray_a), 32'h2);

    // ---- A: reset colliding with tick, en and load ---------------------------
    cyc(3);
    check("a_rc_tick", 32'(tick_a), 32'h1);
    rst = 1'b1; load_a = 1'b1; lg_a = 4'b0110;
    cyc(1);
    check("a_rc_bin",  32'(bin_a),  32'h0);
    check("a_rc_gray", 32'(gray_a), 32'h0);
    check("a_rc_tc",   32'(tc_a),   32'h0);
    check("a_rc_tick0", 32'(tick_a), 32'h0);
    rst = 1'b0; load_a = 1'b0;
    cyc(2);
    check("a_rc_tick_n2", 32'(tick_a), 32'h0);
    cyc(1);
    check("a_rc_tick_n3", 32'(tick_a), 32'h1);
    cyc(1);
    check("a_rc_step_bin", 32'(bin_a), 32'hF);
    check("a_rc_step_tc",  32'(tc_a),  32'h1);
    en_a = 1'b0;

    // ---- B: saturating mode -------------------------------------------------
    rst = 1'b1;
    cyc(2);
    rst = 1'b0; load_b = 1'b1; lg_b = 4'b1000; up_b = 1'b1; en_b = 1'b0;
    cyc(1);
    load_b = 1'b0;
    check("b_ld_bin",  32'(bin_b),  32'hF);
    check("b_ld_gray", 32'(gray_b), 32'h8);
    check("b_ld_tc",   32'(tc_b),   32'h0);
    en_b = 1'b1;
    cyc(3);
    check("b_sat1_bin",  32'(bin_b),  32'hF);
    check("b_sat1_gray", 32'(gray_b), 32'h8);
    check("b_sat1_tc",   32'(tc_b),   32'h1);
    cyc(1);
    check("b_sat1_tc_drop", 32'(tc_b), 32'h0);
    cyc(3);
    check("b_sat2_bin", 32'(bin_b), 32'hF);
    check("b_sat2_tc",  32'(tc_b),  32'h1);
    cyc(1);
    up_b = 1'b0;
    check("b_sat2_tc_drop", 32'(tc_b), 32'h0);
    cyc(3);
    check("b_dn_bin",  32'(bin_b),  32'hE);
    check("b_dn_gray", 32'(gray_b), 32'h9);
    check("b_dn_tc",   32'(tc_b),   32'h0);
    load_b = 1'b1; lg_b = 4'b0000;
    cyc(1);
    load_b = 1'b0;
    check("b_ld0_bin", 32'(bin_b), 32'h0);
    cyc(3);
    check("b_sat0_bin",  32'(bin_b),  32'h0);
    check("b_sat0_gray", 32'(gray_b), 32'h0);
    check("b_sat0_tc",   32'(tc_b),   32'h1);
    cyc(1);
    check("b_sat0_tc_drop", 32'(tc_b), 32'h0);
    en_b = 1'b0;

    // ---- C: DIV=1, 8-bit sweep over a full wrap -----------------------------
    rst = 1'b1;
    cyc(2);
    check("c_rst_bin",  32'(bin_c),  32'h0);
    check("c_rst_tick", 32'(tick_c), 32'h1);
    rst = 1'b0; en_c = 1'b1; up_c = 1'b1;
    prev_gray_c = 8'h00;
    for (int k = 1; k <= 256; k++) begin
      cyc(1);
      check($sformatf("c_bin_%0d", k), 32'(bin_c), 32'(k % 256));
      check($sformatf("c_onebit_%0d", k),
            32'($countones(gray_c ^ prev_gray_c)), 32'h1);
      check($sformatf("c_tc_%0d", k), 32'(tc_c), (k == 256) ? 32'h1 : 32'h0);
      prev_gray_c = gray_c;
    end
    en_c = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gray_updown_counter.md
GRAY_UPDOWN_COUNTER -- requirements
Module: gray_updown_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter width in bits (legal 2..16).
REQ-002 SHALL have parameter DIV, default 100_000_000, clk cycles per step tick (legal >= 1).
REQ-003 SHALL have parameter WRAP, default 1; 1 = wrap-around, 0 = saturate at limits.
REQ-004 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port en  input  1  step enable, sampled only on tick cycles.
REQ-007 SHALL have port up  input  1  direction: 1 = increment, 0 = decrement.
REQ-008 SHALL have port load  input  1  synchronous load request, not gated by tick or en.
REQ-009 SHALL have port load_gray  input  WIDTH  load value, Gray-coded.
REQ-010 SHALL have port tick  output  1  combinational, high in the cycle where prescaler = DIV-1.
REQ-011 SHALL have port bin  output  WIDTH  registered binary count.
REQ-012 SHALL have port gray  output  WIDTH  registered Gray code of bin, always consistent with bin in the same cycle.
REQ-013 SHALL have port tc  output  1  registered terminal-count pulse.

Function
REQ-014 Prescaler SHALL be a free-running counter 0..DIV-1 that returns to 0 after DIV-1; the width is the minimum needed to hold DIV-1.
REQ-015 DIV = 1 SHALL hold tick high every cycle.
REQ-016 Per-edge priority SHALL be rst > load > step > hold.
REQ-017 On load, bin SHALL take the Gray-to-binary conversion of load_gray (b[MSB] = g[MSB]; b[i] = b[i+1] XOR g[i]); gray SHALL take load_gray; tc SHALL be 0.
REQ-018 Load SHALL NOT reset or pause the prescaler.
REQ-019 A step SHALL occur on the edge that ends a cycle with tick=1, en=1, load=0.
REQ-020 Up step SHALL give bin+1 modulo 2^WIDTH; down step SHALL give bin-1 modulo 2^WIDTH.
REQ-021 With WRAP=0, an up step at all-ones and a down step at 0 SHALL leave bin unchanged (saturate).
REQ-022 gray SHALL be registered from the next binary value as next ^ (next >> 1), so the Gray output has zero lag relative to bin.
REQ-023 On every step, tc SHALL be 1 for exactly one cycle if the pre-step value was the boundary for the step direction: all-ones when up, 0 when down. This applies to both WRAP modes, including a blocked saturating step.
REQ-024 tc SHALL be 0 in all other cycles.
REQ-025 A change of up between ticks SHALL take effect at the next tick, with no extra latency.
REQ-026 Successive gray values produced by steps SHALL differ in exactly one bit, except a blocked saturating step, which changes no bit.

Reset
REQ-027 On rst=1 at a clock edge: prescaler = 0, bin = 0, gray = 0, tc = 0.
REQ-028 rst SHALL override a simultaneous load or step, and SHALL abort an in-progress prescale period.
REQ-029 After rst falls, the first tick SHALL occur in the DIV-th cycle, i.e. the cycle where prescaler = DIV-1.
REQ-030 No output SHALL depend on initial-value declarations; reset alone defines state.

Verification (WIDTH=4, DIV=4 unless noted)
REQ-031 Reset release, en=1, up=1 -> tick every 4th cycle; gray sequence 0000, 0001, 0011, 0010, 0110 ... 1000, then 0000 with tc pulsed once on the 1111->0000 step.
REQ-032 up=0 from reset, en=1 -> first step: bin = 1111, gray = 1000, tc = 1 for one cycle; next step: bin = 1110, gray = 1001, tc = 0.
REQ-033 WRAP=0, load load_gray = 1000 (bin 1111), up=1, en=1 -> bin holds at 1111, tc pulses at each tick; then up=0 -> bin = 1110 at the next tick.
REQ-034 load=1 with load_gray = 0110 asserted in a tick cycle with en=1 -> bin = 0100, gray = 0110, no step, tc = 0; prescaler phase unchanged.
REQ-035 rst asserted in the same cycle as tick with en=1 and load=1 -> bin = 0, gray = 0, tc = 0; next tick 4 cycles after rst falls.
REQ-036 DIV=1, WIDTH=8, en=1, up=1 for 256 cycles -> every step changes exactly one gray bit; a single tc pulse occurs on the 255->0 step.
